// File: rtl/pll_cfg_pkg.sv
// Shared constants, register-bus structs and the sequencer state encoding
// for the PLL configuration master and its responder.
package pll_cfg_pkg;

    localparam int unsigned PLL_REG_AW = 32;
    localparam int unsigned PLL_REG_DW = 32;

    localparam logic [11:0] PLL_BYPASS_OFFS = 12'h000;
    localparam logic [11:0] PLL_SEL_OFFS    = 12'h008;
    localparam logic [11:0] PLL_CODE_OFFS   = 12'h010;

    localparam int unsigned PLL_SEL_W  = 3;
    localparam int unsigned PLL_CODE_W = 12;

    typedef struct packed {
        logic                    valid;
        logic                    write;
        logic [PLL_REG_AW-1:0]   addr;
        logic [PLL_REG_DW-1:0]   wdata;
        logic [PLL_REG_DW/8-1:0] wstrb;
    } pll_reg_req_t;

    typedef struct packed {
        logic                  ready;
        logic [PLL_REG_DW-1:0] rdata;
        logic                  error;
    } pll_reg_rsp_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_BYP1 = 4'd1,
        ST_WR_SEL  = 4'd2,
        ST_WR_CODE = 4'd3,
        ST_SETTLE  = 4'd4,
        ST_WR_BYP0 = 4'd5,
        ST_RD_SEL  = 4'd6,
        ST_RD_CODE = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERR     = 4'd9
    } pll_cfg_state_e;

endpackage

// File: rtl/pll_cfg_master.sv
// Register-bus initiator running the PLL bypass/reprogram/settle sequence.
// Optional readback verification of sel/code is enabled by PLL_CFG_READBACK_EN.
module pll_cfg_master
    import pll_cfg_pkg::*;
#(
    parameter type reg_req_t = pll_reg_req_t,
    parameter type reg_rsp_t = pll_reg_rsp_t,
    parameter int unsigned AddrWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr = '0,
    parameter int unsigned SettleCycles  = 1024,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [PLL_SEL_W-1:0]  sel_i,
    input  logic [PLL_CODE_W-1:0] code_bp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output reg_req_t              req_o,
    input  reg_rsp_t              rsp_i,
    output pll_cfg_state_e        dbg_state_o
);

    pll_cfg_state_e        r_state;
    pll_cfg_state_e        w_next;
    logic [PLL_SEL_W-1:0]  r_sel;
    logic [PLL_CODE_W-1:0] r_code;
    logic                  r_error;
    logic [31:0]           r_settle_cnt;
    logic [31:0]           r_to_cnt;

    logic                  w_is_req;
    logic                  w_write;
    logic [11:0]           w_offs;
    logic [PLL_REG_DW-1:0] w_wdata;
    logic                  w_xfer;
    logic                  w_timeout;
    logic                  w_rd_mismatch;
    logic                  w_unused_rdata;

    always_comb begin
        w_is_req = 1'b0;
        w_write  = 1'b1;
        w_offs   = PLL_BYPASS_OFFS;
        w_wdata  = '0;
        case (r_state)
            ST_WR_BYP1: begin
                w_is_req = 1'b1;
                w_wdata  = 32'd1;
            end
            ST_WR_SEL: begin
                w_is_req = 1'b1;
                w_offs   = PLL_SEL_OFFS;
                w_wdata  = 32'(r_sel);
            end
            ST_WR_CODE: begin
                w_is_req = 1'b1;
                w_offs   = PLL_CODE_OFFS;
                w_wdata  = 32'(r_code);
            end
            ST_WR_BYP0: w_is_req = 1'b1;
`ifdef PLL_CFG_READBACK_EN
            ST_RD_SEL: begin
                w_is_req = 1'b1;
                w_write  = 1'b0;
                w_offs   = PLL_SEL_OFFS;
            end
            ST_RD_CODE: begin
                w_is_req = 1'b1;
                w_write  = 1'b0;
                w_offs   = PLL_CODE_OFFS;
            end
`endif
            default: ;
        endcase
    end

    assign w_xfer         = w_is_req && rsp_i.ready;
    assign w_timeout      = w_is_req && !rsp_i.ready && (TimeoutCycles != 0) &&
                            (r_to_cnt == TimeoutCycles - 1);
    assign w_unused_rdata = ^rsp_i.rdata;

`ifdef PLL_CFG_READBACK_EN
    assign w_rd_mismatch = ((r_state == ST_RD_SEL)  && (rsp_i.rdata[PLL_SEL_W-1:0]  != r_sel)) ||
                           ((r_state == ST_RD_CODE) && (rsp_i.rdata[PLL_CODE_W-1:0] != r_code));
`else
    assign w_rd_mismatch = 1'b0;
`endif

    // SETTLE occupies max(SettleCycles, 1) cycles: it exits on the cycle the
    // counter is about to reach zero, so a zero setting still takes one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start_i) w_next = ST_WR_BYP1;
            ST_WR_BYP1: if (w_xfer) w_next = ST_WR_SEL;
            ST_WR_SEL:  if (w_xfer) w_next = ST_WR_CODE;
            ST_WR_CODE: if (w_xfer) w_next = ST_SETTLE;
            ST_SETTLE:  if (r_settle_cnt <= 32'd1) w_next = ST_WR_BYP0;
`ifdef PLL_CFG_READBACK_EN
            ST_WR_BYP0: if (w_xfer) w_next = ST_RD_SEL;
            ST_RD_SEL:  if (w_xfer) w_next = ST_RD_CODE;
            ST_RD_CODE: if (w_xfer) w_next = ST_DONE;
`else
            ST_WR_BYP0: if (w_xfer) w_next = ST_DONE;
`endif
            ST_DONE:    w_next = ST_IDLE;
            ST_ERR:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if ((w_xfer && (rsp_i.error || w_rd_mismatch)) || w_timeout) begin
            w_next = ST_ERR;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_code       <= '0;
            r_error      <= 1'b0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start_i) begin
                r_sel   <= sel_i;
                r_code  <= code_bp_i;
                r_error <= 1'b0;
            end else if (w_next == ST_ERR) begin
                r_error <= 1'b1;
            end
            // Counts only stalled cycles, so it restarts for every request.
            if (!w_is_req || rsp_i.ready) r_to_cnt <= '0;
            else                          r_to_cnt <= r_to_cnt + 32'd1;
            if (r_state == ST_WR_CODE && w_xfer) begin
                r_settle_cnt <= SettleCycles;
            end else if (r_state == ST_SETTLE && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - 32'd1;
            end
        end
    end

    always_comb begin
        req_o       = '0;
        req_o.valid = w_is_req;
        req_o.write = w_is_req && w_write;
        req_o.addr  = w_is_req ? AddrWidth'(BaseAddr + AddrWidth'(w_offs)) : '0;
        req_o.wdata = w_wdata;
        req_o.wstrb = (w_is_req && w_write) ? '1 : '0;
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_DONE);
    assign error_o     = r_error;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pll_cfg_master.sv
// Self-checking bench for pll_cfg_master: responder model with stall/error
// injection, table-driven and randomized sequences, timeout and reset cases.
module tb_pll_cfg_master;
    import pll_cfg_pkg::*;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 8;
    localparam logic [31:0] BASE   = 32'h4000_0000;
`ifdef PLL_CFG_READBACK_EN
    localparam int NREQ = 6;
`else
    localparam int NREQ = 4;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     sel = '0;
    logic [11:0]    code = '0;
    logic           busy, done, error;
    pll_reg_req_t   req;
    pll_reg_rsp_t   rsp = '0;
    pll_cfg_state_e dbg;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pll_cfg_master #(
        .AddrWidth(32), .BaseAddr(BASE), .SettleCycles(SETTLE), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .sel_i(sel), .code_bp_i(code),
        .busy_o(busy), .done_o(done), .error_o(error), .req_o(req), .rsp_i(rsp),
        .dbg_state_o(dbg)
    );

    // Responder model: per-request stall, error on a chosen request index,
    // optional readback corruption; completed requests land in obs_q.
    int           stall_cfg = 0, stall_cnt = 0, err_idx = -1, req_idx = 0;
    bit           hold_low = 1'b0, corrupt = 1'b0;
    logic [31:0]  reg_byp = '0, reg_sel = '0, reg_code = '0;
    logic [64:0]  obs_q[$];
    logic [64:0]  exp_q[$];
    pll_reg_req_t snap;
    int           unstable = 0, idle_cnt = 0, done_cnt = 0, valid_cnt = 0;

    always @(negedge clk) begin
        rsp = '0;
        if (busy && !req.valid && !done && !error) idle_cnt++;
        if (done) done_cnt++;
        if (req.valid) begin
            valid_cnt++;
            if (stall_cnt > 0 && req != snap) unstable++;
            if (stall_cnt == 0) snap = req;
            if (!hold_low && stall_cnt >= stall_cfg) begin
                rsp.ready = 1'b1;
                rsp.error = (req_idx == err_idx);
                case (req.addr - BASE)
                    32'h000: rsp.rdata = reg_byp;
                    32'h008: rsp.rdata = reg_sel;
                    32'h010: rsp.rdata = corrupt ? reg_code + 32'd1 : reg_code;
                    default: rsp.rdata = '0;
                endcase
                obs_q.push_back({req.write, req.addr, req.write ? req.wdata : 32'h0});
                if (req.write && !rsp.error) begin
                    case (req.addr - BASE)
                        32'h000: reg_byp  = req.wdata;
                        32'h008: reg_sel  = req.wdata;
                        32'h010: reg_code = req.wdata;
                        default: ;
                    endcase
                end
                req_idx++;
                stall_cnt = 0;
            end else begin
                stall_cnt++;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: the full ordered request list, truncated at the failing request.
    task automatic build_expected(input logic [2:0] s, input logic [11:0] c, input int fail_at,
                                  output int n_done);
        logic [64:0] full[$];
        full.delete();
        full.push_back({1'b1, BASE + 32'h000, 32'd1});
        full.push_back({1'b1, BASE + 32'h008, 32'(s)});
        full.push_back({1'b1, BASE + 32'h010, 32'(c)});
        full.push_back({1'b1, BASE + 32'h000, 32'd0});
`ifdef PLL_CFG_READBACK_EN
        full.push_back({1'b0, BASE + 32'h008, 32'd0});
        full.push_back({1'b0, BASE + 32'h010, 32'd0});
`endif
        n_done = (fail_at < 0) ? NREQ : fail_at + 1;
        exp_q.delete();
        for (int i = 0; i < n_done; i++) exp_q.push_back(full[i]);
    endtask

    task automatic run_seq(input string tag, input logic [2:0] s, input logic [11:0] c,
                           input int stall, input int inj, input bit corr,
                           input bit exp_err, input bit exp_done);
        int n, n_done, fail_at, exp_lat, settle_c;
        fail_at = (inj >= 0) ? inj : (corr ? 5 : -1);
        build_expected(s, c, fail_at, n_done);
        settle_c = (n_done >= 4) ? ((SETTLE == 0) ? 1 : int'(SETTLE)) : 0;
        exp_lat  = n_done * (1 + stall) + settle_c + 1;
        @(negedge clk);
        stall_cfg = stall; err_idx = inj; corrupt = corr; req_idx = 0;
        obs_q.delete(); idle_cnt = 0; done_cnt = 0; unstable = 0;
        sel = s; code = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, " err_cleared"}, 80'(error), 80'(0));
        check({tag, " busy"}, 80'(busy), 80'(1));
        while (!(done || error) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 80'(n), 80'(exp_lat));
        check({tag, " done"}, 80'(done), 80'(exp_done));
        check({tag, " error"}, 80'(error), 80'(exp_err));
        @(negedge clk);
        #1;
        check({tag, " busy_after"}, 80'(busy), 80'(0));
        check({tag, " idle_state"}, 80'(dbg), 80'(ST_IDLE));
        check({tag, " error_sticky"}, 80'(error), 80'(exp_err));
        check({tag, " n_reqs"}, 80'(obs_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, " req"}, 80'(obs_q[i]), 80'(exp_q[i]));
        check({tag, " settle_idle"}, 80'(idle_cnt), 80'(settle_c));
        check({tag, " done_pulses"}, 80'(done_cnt), 80'(exp_done));
        check({tag, " stable"}, 80'(unstable), 80'(0));
        if (exp_done) begin
            check({tag, " reg_byp"}, 80'(reg_byp), 80'(0));
            check({tag, " reg_sel"}, 80'(reg_sel), 80'(s));
            check({tag, " reg_code"}, 80'(reg_code), 80'(c));
        end else if (fail_at >= 1 && fail_at <= 3) begin
            check({tag, " byp_left_on"}, 80'(reg_byp), 80'(1));
        end
        err_idx = -1; corrupt = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] code;
        int          stall;
        int          inj;
        bit          exp_err;
        bit          exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{3'h5, 12'hABC, 0, -1, 1'b0, 1'b1};
        vecs[1] = '{3'h5, 12'hABC, 3, -1, 1'b0, 1'b1};
        vecs[2] = '{3'h2, 12'h123, 0,  1, 1'b1, 1'b0};
        vecs[3] = '{3'h7, 12'hFFF, 1, -1, 1'b0, 1'b1};
        vecs[4] = '{3'h0, 12'h000, 2,  3, 1'b1, 1'b0};
        vecs[5] = '{3'h1, 12'h001, 0,  0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst valid", 80'(req.valid), 80'(0));
        check("rst req", 80'(req), 80'(0));
        check("rst busy", 80'(busy), 80'(0));
        check("rst done", 80'(done), 80'(0));
        check("rst error", 80'(error), 80'(0));
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_seq($sformatf("vec%0d", i), vecs[i].sel, vecs[i].code, vecs[i].stall,
                    vecs[i].inj, 1'b0, vecs[i].exp_err, vecs[i].exp_done);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  rs;
            logic [11:0] rc;
            int          st, inj;
            rs  = 3'($urandom_range(0, 7));
            rc  = 12'($urandom_range(0, 4095));
            st  = $urandom_range(0, 3);
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREQ - 1) : -1;
            run_seq($sformatf("rnd%0d", i), rs, rc, st, inj, 1'b0, inj >= 0, inj < 0);
        end

`ifdef PLL_CFG_READBACK_EN
        run_seq("readback_corrupt", 3'h5, 12'hABC, 0, -1, 1'b1, 1'b1, 1'b0);
`endif

        // Ready held low: valid for exactly TMO cycles, then ERR.
        @(negedge clk);
        hold_low = 1'b1; valid_cnt = 0;
        sel = 3'h3; code = 12'h456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!error && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo cycles", 80'(n), 80'(TMO + 1));
        check("tmo valid_cnt", 80'(valid_cnt), 80'(TMO));
        check("tmo valid_dropped", 80'(req.valid), 80'(0));
        check("tmo error", 80'(error), 80'(1));
        @(negedge clk);
        check("tmo idle", 80'(busy), 80'(0));
        hold_low = 1'b0;

        // Extra start mid-sequence is ignored; reset during the code-write stall.
        @(negedge clk);
        stall_cfg = 3; req_idx = 0; obs_q.delete();
        sel = 3'h5; code = 12'hABC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!(req.valid && req.addr == BASE + 32'h010) && n < 100) begin
            @(negedge clk);
            n++;
            start = (n == 4);
        end
        start = 1'b0;
        check("rstmid reached_code", 80'(req.addr), 80'(BASE + 32'h010));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rstmid valid", 80'(req.valid), 80'(0));
        check("rstmid req", 80'(req), 80'(0));
        check("rstmid busy", 80'(busy), 80'(0));
        check("rstmid done", 80'(done), 80'(0));
        check("rstmid error", 80'(error), 80'(0));
        check("rstmid state", 80'(dbg), 80'(ST_IDLE));
        check("rstmid n_reqs", 80'(obs_q.size()), 80'(2));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        stall_cfg = 0;
        run_seq("after_rst", 3'h6, 12'h5A5, 0, -1, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
